instr_fetch: RTL and testbench

//  Instruction fetch (IF) stage. Owns the PC and issues in-order fetches on the instruction bus.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 14 +
 rtl/instr_fetch_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t CORE_NOP_INSTR = 32'h0000_0013;
    localparam word_t CORE_PC_STEP   = 32'd4;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_word_t;

    function automatic word_t align_pc(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction bus: in-order request/grant with in-order read responses.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic  req;
    word_t addr;
    logic  gnt;
    logic  rvalid;
    word_t rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO with async active-low reset and a synchronous flush.
module instr_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, issues in-order fetches, buffers responses, drives the IF/ID register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter word_t       RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master ibus,
    input  logic          if_stall,
    input  logic          branch_take,
    input  word_t         branch_target,
    input  logic          trap_take,
    input  word_t         trap_vector,
    output logic          if2id_valid,
    output word_t         if2id_pc,
    output word_t         if2id_instruction
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SumW = CntW + 1;

    logic            active_q;
    word_t           fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] kill_q, kill_d;
    logic            if2id_valid_d;
    word_t           if2id_pc_d, if2id_instr_d;

    logic            redirect, issue, rsp, live;
    word_t           redirect_pc, pend_pc;
    logic            pend_full, pend_empty, buf_full, buf_empty, buf_push, buf_pop;
    logic [CntW-1:0] pend_count, buf_count;
    fetch_word_t     rsp_word, buf_head;

    assign redirect    = trap_take | branch_take;
    assign redirect_pc = align_pc(trap_take ? trap_vector : branch_target);

    // Pending-PC occupancy is the in-flight count; in-flight plus buffered never exceeds the
    // buffer depth, so every returning word always has a slot.
    assign ibus.req  = active_q && !redirect && !pend_full && !buf_full &&
                       ((SumW'(pend_count) + SumW'(buf_count)) < SumW'(MAX_OUTSTANDING));
    assign ibus.addr = fetch_pc_q;

    assign issue    = ibus.req & ibus.gnt;
    assign rsp      = ibus.rvalid & !pend_empty;
    assign live     = rsp && (kill_q == '0) && !redirect;
    assign rsp_word = {pend_pc, ibus.rdata};
    assign buf_pop  = !redirect && !if_stall && !buf_empty;
    assign buf_push = live && (if_stall || !buf_empty);

    instr_fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (issue),
        .wdata (fetch_pc_q),
        .pop   (rsp),
        .rdata (pend_pc),
        .full  (pend_full),
        .empty (pend_empty),
        .count (pend_count)
    );

    instr_fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (buf_push),
        .wdata (rsp_word),
        .pop   (buf_pop),
        .rdata (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // Everything still in flight is wrong-path, including earlier kills.
            kill_d     = pend_count - CntW'(rsp);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + CORE_PC_STEP;
            if (rsp && kill_q != '0) kill_d = kill_q - CntW'(1);
        end
    end

    always_comb begin
        if2id_valid_d = if2id_valid;
        if2id_pc_d    = if2id_pc;
        if2id_instr_d = if2id_instruction;
        if (redirect) begin
            if2id_valid_d = 1'b0;
        end else if (!if_stall) begin
            if (!buf_empty) begin
                if2id_valid_d = 1'b1;
                if2id_pc_d    = buf_head.pc;
                if2id_instr_d = buf_head.instr;
            end else if (live) begin
                if2id_valid_d = 1'b1;
                if2id_pc_d    = rsp_word.pc;
                if2id_instr_d = rsp_word.instr;
            end else begin
                if2id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q          <= 1'b0;
            fetch_pc_q        <= RESET_PC;
            kill_q            <= '0;
            if2id_valid       <= 1'b0;
            if2id_pc          <= RESET_PC;
            if2id_instruction <= CORE_NOP_INSTR;
        end else begin
            active_q          <= 1'b1;
            fetch_pc_q        <= fetch_pc_d;
            kill_q            <= kill_d;
            if2id_valid       <= if2id_valid_d;
            if2id_pc          <= if2id_pc_d;
            if2id_instruction <= if2id_instr_d;
        end
    end

    rvalid_tracked: assert property (@(posedge clk) disable iff (!rst)
        ibus.rvalid |-> !pend_empty);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a bus responder and an in-order scoreboard.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam word_t PAT = 32'hA5A5_0000;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  if_stall = 1'b0, branch_take = 1'b0, trap_take = 1'b0;
    word_t branch_target = '0, trap_vector = '0;
    logic  if2id_valid;
    word_t if2id_pc, if2id_instruction;

    instr_fetch_if ibus ();

    int          checks = 0;
    int          errors = 0;
    bit          gnt_en = 1'b0;
    bit          hold = 1'b0;
    word_t       bus_q[$];
    logic [63:0] exp_q[$];

    instr_fetch #(
        .RESET_PC        (32'h0000_0000),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ibus              (ibus),
        .if_stall          (if_stall),
        .branch_take       (branch_take),
        .branch_target     (branch_target),
        .trap_take         (trap_take),
        .trap_vector       (trap_vector),
        .if2id_valid       (if2id_valid),
        .if2id_pc          (if2id_pc),
        .if2id_instruction (if2id_instruction)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < n && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = if2id_valid;
        end
    endtask

    // Bus responder, scoreboard push on issue, in-order compare of consumed IF/ID words.
    initial begin
        word_t       a;
        logic [63:0] e;
        ibus.gnt    = 1'b0;
        ibus.rvalid = 1'b0;
        ibus.rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                bus_q.delete();
                exp_q.delete();
                ibus.rvalid = 1'b0;
            end else if (!hold && bus_q.size() > 0) begin
                a           = bus_q.pop_front();
                ibus.rvalid = 1'b1;
                ibus.rdata  = a ^ PAT;
            end else begin
                ibus.rvalid = 1'b0;
            end
            ibus.gnt = gnt_en;
            #1;
            if (rst && if2id_valid && !if_stall && !branch_take && !trap_take) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_empty got pc=%h exp=<none>", if2id_pc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert ({if2id_pc, if2id_instruction} === e) else begin
                        errors++;
                        $error("FAIL sb_word got=%h_%h exp=%h_%h", if2id_pc,
                               if2id_instruction, e[63:32], e[31:0]);
                    end
                end
            end
            if (branch_take || trap_take) exp_q.delete();
            if (rst && ibus.req && ibus.gnt) begin
                bus_q.push_back(ibus.addr);
                exp_q.push_back({ibus.addr, ibus.addr ^ PAT});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(if2id_valid), 32'd0);
        chk("rst_pc", if2id_pc, 32'h0);
        chk("rst_instr", if2id_instruction, 32'h13);
        chk("rst_req", 32'(ibus.req), 32'd0);

        // 1: streaming at one instruction per cycle
        @(negedge clk);
        rst    = 1'b1;
        gnt_en = 1'b1;
        wait_valid(20, found);
        chk("t1_seen", 32'(found), 32'd1);
        chk("t1_first_pc", if2id_pc, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            #1;
            chk("t1_valid", 32'(if2id_valid), 32'd1);
            chk("t1_pc", if2id_pc, 32'(4 * i));
        end

        // 2: three-cycle stall freezes IF/ID, request drops once two words are buffered
        @(negedge clk);
        if_stall = 1'b1;
        #1;
        chk("t2_pc_at_stall", if2id_pc, 32'h24);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("t2_frozen_pc", if2id_pc, 32'h24);
            chk("t2_frozen_instr", if2id_instruction, 32'h24 ^ PAT);
            chk("t2_frozen_valid", 32'(if2id_valid), 32'd1);
            chk("t2_req_low", 32'(ibus.req), 32'd0);
        end
        @(negedge clk);
        if_stall = 1'b0;
        #1;
        chk("t2_release_pc", if2id_pc, 32'h24);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            #1;
            chk("t2_order_valid", 32'(if2id_valid), 32'd1);
            chk("t2_order_pc", if2id_pc, 32'h24 + 32'(4 * i));
        end

        // 3: branch with two requests in flight
        @(negedge clk);
        hold = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("t3_req_inflight_limit", 32'(ibus.req), 32'd0);
        @(negedge clk);
        branch_take   = 1'b1;
        branch_target = 32'h0000_0103;
        #1;
        chk("t3_req_redirect", 32'(ibus.req), 32'd0);
        @(negedge clk);
        branch_take = 1'b0;
        hold        = 1'b0;
        #1;
        chk("t3_addr", ibus.addr, 32'h100);
        chk("t3_valid_cleared", 32'(if2id_valid), 32'd0);
        chk("t3_req_kill_pending", 32'(ibus.req), 32'd0);
        wait_valid(20, found);
        chk("t3_seen", 32'(found), 32'd1);
        chk("t3_pc", if2id_pc, 32'h100);
        chk("t3_instr", if2id_instruction, 32'h100 ^ PAT);

        // 4: trap wins over a simultaneous branch
        repeat (3) @(negedge clk);
        trap_take     = 1'b1;
        branch_take   = 1'b1;
        trap_vector   = 32'h0000_0200;
        branch_target = 32'h0000_0100;
        #1;
        chk("t4_req_redirect", 32'(ibus.req), 32'd0);
        @(negedge clk);
        trap_take   = 1'b0;
        branch_take = 1'b0;
        #1;
        chk("t4_addr", ibus.addr, 32'h200);
        chk("t4_req", 32'(ibus.req), 32'd1);
        wait_valid(20, found);
        chk("t4_seen", 32'(found), 32'd1);
        chk("t4_pc", if2id_pc, 32'h200);

        // 5: grant withheld for four cycles
        @(negedge clk);
        gnt_en = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            chk("t5_req_held", 32'(ibus.req), 32'd1);
            chk("t5_addr_held", ibus.addr, 32'h20C);
        end
        @(negedge clk);
        gnt_en = 1'b1;
        #1;
        chk("t5_addr_at_grant", ibus.addr, 32'h20C);
        @(negedge clk);
        #1;
        chk("t5_addr_after_grant", ibus.addr, 32'h210);

        // 6: asynchronous reset between clock edges
        repeat (4) @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(if2id_valid), 32'd0);
        chk("t6_req", 32'(ibus.req), 32'd0);
        chk("t6_pc", if2id_pc, 32'h0);
        chk("t6_instr", if2id_instruction, 32'h13);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            #1;
            found = ibus.req;
        end
        chk("t6_req_seen", 32'(found), 32'd1);
        chk("t6_first_addr", ibus.addr, 32'h0);
        wait_valid(20, found);
        chk("t6_seen", 32'(found), 32'd1);
        chk("t6_first_pc", if2id_pc, 32'h0);

        // Drain and confirm every issued correct-path word was delivered
        @(negedge clk);
        gnt_en = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
